load_hazard_ctrl: RTL and testbench

LOAD_HAZARD_CTRL -- requirements
Module: load_hazard_ctrl

---
 rtl/load_hazard_ctrl.sv | 165 ++++++++++++++++
 tb/tb_load_hazard_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/load_hazard_ctrl.sv
// load_hazard_ctrl: load-use, branch-flush and memory-wait pipeline control.
// Define HAZ_ZERO_REG_EN to keep register 0 out of load-use detection.
module load_hazard_ctrl #(
    parameter int REG_AW      = 4,
    parameter int NUM_SRC     = 2,
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      ex_memread,
    input  logic [REG_AW-1:0]         ex_rd,
    input  logic [NUM_SRC*REG_AW-1:0] id_src,
    input  logic [NUM_SRC-1:0]        id_src_valid,
    input  logic                      mem_req,
    input  logic                      mem_ready,
    input  logic                      branch_taken,
    input  logic                      perf_clr,
    output logic                      pc_pause,
    output logic                      if_id_pause,
    output logic                      if_id_flush,
    output logic                      id_flush,
    output logic                      ex_hold,
    output logic                      mem_timeout,
    output logic [CNT_W-1:0]          stall_cnt
);

    typedef enum logic {
        S_IDLE     = 1'b0,
        S_MEM_WAIT = 1'b1
    } state_t;

    localparam logic [7:0] LP_LAST = 8'(MEM_TIMEOUT - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [7:0]       r_wait_cnt;
    logic [7:0]       w_wait_cnt_nxt;
    logic [CNT_W-1:0] r_stall_cnt;

    logic w_load_use;
    logic w_mem_stall;
    logic w_mem_done;
    logic w_wait_last;

    logic w_pc_pause;
    logic w_if_id_pause;
    logic w_if_id_flush;
    logic w_id_flush;
    logic w_ex_hold;
    logic w_mem_timeout;

    // Each operand is paired only with the load destination.
    always_comb begin
        w_load_use = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (id_src_valid[i] &&
                (id_src[i*REG_AW +: REG_AW] == ex_rd)) begin
                w_load_use = 1'b1;
            end
        end
`ifdef HAZ_ZERO_REG_EN
        if (ex_rd == '0) begin
            w_load_use = 1'b0;
        end
`else
        w_load_use = w_load_use;
`endif
        w_load_use = w_load_use & ex_memread;
    end

    assign w_mem_stall = mem_req & ~mem_ready;
    assign w_mem_done  = ~mem_req | mem_ready;
    assign w_wait_last = (r_wait_cnt == LP_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_wait_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_wait_cnt_nxt = r_wait_cnt;
        unique case (r_state)
            S_IDLE: begin
                if (w_mem_stall) begin
                    w_state_nxt    = S_MEM_WAIT;
                    w_wait_cnt_nxt = '0;
                end
            end
            S_MEM_WAIT: begin
                if (w_mem_done || w_wait_last) begin
                    w_state_nxt    = S_IDLE;
                    w_wait_cnt_nxt = '0;
                end else begin
                    w_wait_cnt_nxt = r_wait_cnt + 8'd1;
                end
            end
            default: begin
                w_state_nxt    = S_IDLE;
                w_wait_cnt_nxt = '0;
            end
        endcase
    end

    always_comb begin
        w_pc_pause    = 1'b0;
        w_if_id_pause = 1'b0;
        w_if_id_flush = 1'b0;
        w_id_flush    = 1'b0;
        w_ex_hold     = 1'b0;
        w_mem_timeout = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_mem_stall) begin
                    w_pc_pause    = 1'b1;
                    w_if_id_pause = 1'b1;
                    w_ex_hold     = 1'b1;
                end else if (branch_taken) begin
                    w_if_id_flush = 1'b1;
                    w_id_flush    = 1'b1;
                end else if (w_load_use) begin
                    w_pc_pause    = 1'b1;
                    w_if_id_pause = 1'b1;
                    w_id_flush    = 1'b1;
                end
            end
            S_MEM_WAIT: begin
                // Frozen stages re-present branch/load-use after exit.
                w_pc_pause    = 1'b1;
                w_if_id_pause = 1'b1;
                w_ex_hold     = 1'b1;
                w_mem_timeout = w_mem_stall & w_wait_last;
            end
            default: begin
                w_pc_pause = 1'b0;
            end
        endcase
    end

    assign pc_pause    = w_pc_pause & rst_n;
    assign if_id_pause = w_if_id_pause & rst_n;
    assign if_id_flush = w_if_id_flush & rst_n;
    assign id_flush    = w_id_flush & rst_n;
    assign ex_hold     = w_ex_hold & rst_n;
    assign mem_timeout = w_mem_timeout & rst_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (perf_clr) begin
            r_stall_cnt <= '0;
        end else if (w_pc_pause && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_load_hazard_ctrl.sv
// tb_load_hazard_ctrl: directed and random stimulus for load_hazard_ctrl,
// checked against a cycle-level behavioural model.
module tb_load_hazard_ctrl;

    localparam int AW  = 4;
    localparam int NS  = 2;
    localparam int TO  = 4;
    localparam int CW  = 4;
    localparam int MAXC = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          ex_memread;
    logic [AW-1:0] ex_rd;
    logic [NS*AW-1:0] id_src;
    logic [NS-1:0] id_src_valid;
    logic          mem_req;
    logic          mem_ready;
    logic          branch_taken;
    logic          perf_clr;
    logic          pc_pause;
    logic          if_id_pause;
    logic          if_id_flush;
    logic          id_flush;
    logic          ex_hold;
    logic          mem_timeout;
    logic [CW-1:0] stall_cnt;

    int n_err = 0;
    int n_chk = 0;

    bit m_wait;
    int m_wcnt;
    int m_stall;

    load_hazard_ctrl #(
        .REG_AW(AW), .NUM_SRC(NS), .MEM_TIMEOUT(TO), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .ex_memread(ex_memread), .ex_rd(ex_rd),
        .id_src(id_src), .id_src_valid(id_src_valid),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .branch_taken(branch_taken), .perf_clr(perf_clr),
        .pc_pause(pc_pause), .if_id_pause(if_id_pause),
        .if_id_flush(if_id_flush), .id_flush(id_flush),
        .ex_hold(ex_hold), .mem_timeout(mem_timeout),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // {pc_pause, if_id_pause, if_id_flush, id_flush, ex_hold, mem_timeout}
    function automatic logic [5:0] exp_out();
        logic lu;
        lu = 1'b0;
        if (!rst_n) return 6'b0;
        for (int i = 0; i < NS; i++)
            if (id_src_valid[i] && id_src[i*AW +: AW] == ex_rd) lu = 1'b1;
        lu = lu & ex_memread;
`ifdef HAZ_ZERO_REG_EN
        if (ex_rd == 0) lu = 1'b0;
`endif
        if (m_wait)
            return {5'b11001, mem_req && !mem_ready && m_wcnt == TO - 1};
        if (mem_req && !mem_ready) return 6'b110010;
        if (branch_taken) return 6'b001100;
        if (lu) return 6'b110100;
        return 6'b0;
    endfunction

    task automatic model_step(input bit pause);
        if (!rst_n) return;
        if (perf_clr) m_stall = 0;
        else if (pause && m_stall < MAXC) m_stall++;
        if (!m_wait) begin
            if (mem_req && !mem_ready) begin
                m_wait = 1;
                m_wcnt = 0;
            end
        end else if (!mem_req || mem_ready || m_wcnt == TO - 1) begin
            m_wait = 0;
        end else begin
            m_wcnt++;
        end
    endtask

    task automatic cycle(input string tag);
        logic [5:0] e;
        logic [5:0] g;
        #1;
        if (!rst_n) begin
            m_wait  = 0;
            m_wcnt  = 0;
            m_stall = 0;
        end
        e = exp_out();
        g = {pc_pause, if_id_pause, if_id_flush, id_flush, ex_hold,
             mem_timeout};
        check({tag, "/ctl"}, 32'(g), 32'(e));
        check({tag, "/cnt"}, 32'(stall_cnt), 32'(m_stall));
        @(posedge clk);
        model_step(e[5]);
        @(negedge clk);
    endtask

    task automatic idle();
        ex_memread   = 1'b0;
        ex_rd        = '0;
        id_src       = '0;
        id_src_valid = '0;
        mem_req      = 1'b0;
        mem_ready    = 1'b0;
        branch_taken = 1'b0;
        perf_clr     = 1'b0;
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        ex_memread = 1'b1;
        id_src_valid = 2'b11;
        mem_req = 1'b1;
        #1;
        check("rst_out", 32'({pc_pause, if_id_pause, if_id_flush, id_flush,
                              ex_hold, mem_timeout}), 32'd0);
        check("rst_cnt", 32'(stall_cnt), 32'd0);
        cycle("rst0");
        cycle("rst1");
        idle();
        rst_n = 1'b1;
        cycle("idle");

        ex_memread = 1'b1; ex_rd = 4'd3;
        id_src = {4'd5, 4'd3}; id_src_valid = 2'b11;
        cycle("lu_both");
        ex_memread = 1'b0;
        cycle("lu_drop");

        ex_memread = 1'b1; id_src_valid = 2'b10;
        cycle("lu_op0_off");
        ex_rd = 4'd5;
        cycle("lu_op1");
        ex_memread = 1'b0;

        ex_memread = 1'b1; ex_rd = 4'd3; id_src_valid = 2'b11;
        branch_taken = 1'b1;
        cycle("br_lu");
        idle();

        perf_clr = 1'b1;
        cycle("clr");
        perf_clr = 1'b0;
        mem_req = 1'b1;
        repeat (4) cycle("mw_busy");
        mem_ready = 1'b1;
        cycle("mw_ready");
        idle();
        #1;
        check("mw_cnt5", 32'(stall_cnt), 32'd5);
        check("mw_exit", 32'(pc_pause), 32'd0);
        cycle("mw_idle");

        mem_req = 1'b1;
        repeat (4) cycle("to_wait");
        #1;
        check("to_pulse", 32'(mem_timeout), 32'd1);
        cycle("to_last");
        mem_req = 1'b0;
        cycle("to_idle");

        mem_req = 1'b1;
        repeat (3) cycle("drop_wait");
        mem_req = 1'b0;
        cycle("drop_exit");
        cycle("drop_idle");

        mem_req = 1'b1;
        repeat (3) cycle("rmid_wait");
        rst_n = 1'b0;
        #1;
        check("rmid_out", 32'({pc_pause, ex_hold, mem_timeout}), 32'd0);
        cycle("rmid0");
        cycle("rmid1");
        rst_n = 1'b1;
        mem_req = 1'b0;
        cycle("rmid_rel");

        ex_memread = 1'b1; ex_rd = 4'd0;
        id_src = {4'd7, 4'd0}; id_src_valid = 2'b01;
        #1;
`ifdef HAZ_ZERO_REG_EN
        check("r0_lu", 32'(pc_pause), 32'd0);
`else
        check("r0_lu", 32'(pc_pause), 32'd1);
`endif
        cycle("r0");
        idle();

        perf_clr = 1'b1;
        cycle("sat_clr");
        perf_clr = 1'b0;
        ex_memread = 1'b1; ex_rd = 4'd2;
        id_src = {4'd2, 4'd1}; id_src_valid = 2'b11;
        repeat (20) cycle("sat");
        check("sat_cnt", 32'(stall_cnt), 32'd15);
        perf_clr = 1'b1;
        cycle("sat_clr_pri");
        check("sat_clr_cnt", 32'(stall_cnt), 32'd0);
        idle();

        repeat (3000) begin
            rst_n        = ($urandom_range(0, 99) != 0);
            ex_memread   = ($urandom_range(0, 1) == 1);
            ex_rd        = 4'($urandom_range(0, 3));
            id_src       = {4'($urandom_range(0, 3)),
                            4'($urandom_range(0, 3))};
            id_src_valid = 2'($urandom_range(0, 3));
            mem_req      = ($urandom_range(0, 9) < 4);
            mem_ready    = ($urandom_range(0, 9) < 3);
            branch_taken = ($urandom_range(0, 9) < 2);
            perf_clr     = ($urandom_range(0, 49) == 0);
            cycle("rand");
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
